// File: rtl/svc_rv_mem_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   PORT_CPU / PORT_DBG : port identifiers carried in the read-owner register
//   rd_owner_t          : tracks which port owns the read data returning next cycle
package svc_rv_mem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef struct packed {
        logic valid;   // a read was accepted last cycle
        logic port;    // PORT_CPU or PORT_DBG
    } rd_owner_t;

endpackage

// File: rtl/svc_rv_mem_arb_starve.sv
// Saturating refusal counter for the debug/loader port.
// Counts consecutive cycles in which port 1 requests but is not granted.
// Once the count reaches STARVE_MAX, force_grant tells the arbiter to
// hand the next cycle to port 1 regardless of port 0.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : port 1 is requesting (m1_valid)
//   grant        : port 1 was granted this cycle
//   force_grant  : count has reached STARVE_MAX
module svc_rv_mem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic grant,
    output logic force_grant
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (req && !grant) begin
            // Saturate; in practice a grant is forced before overflow.
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign force_grant = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/svc_rv_mem_arb.sv
// Two-port arbiter in front of a single SRAM (1-cycle registered read,
// byte-strobed write). Port 0 is the CPU data path and has fixed priority;
// port 1 is the debug/loader path and is protected from starvation by a
// refusal counter that forces a grant after STARVE_MAX refused cycles.
//
// Handshake: a request transfers in the cycle where valid and ready are
// both high. A requester that sees ready low keeps valid and its payload
// (we, addr, wdata, wstrb) stable until it is accepted. Read data comes
// back exactly one cycle after acceptance with rvalid on the requesting
// port only; rvalid has no back-pressure. Writes return nothing.
//
//   clk, rst                    : clock, asynchronous active-high reset
//   mN_valid/ready/we/addr/     : request channel of port N (0=CPU, 1=debug)
//   mN_wdata/wstrb
//   mN_rvalid/rdata             : read response of port N
//   sram_rd_addr / sram_rd_data : SRAM read port (data valid the next cycle)
//   sram_wr_en/addr/data/strb   : SRAM write port
//   starved                     : one-cycle pulse after a forced port-1 grant
module svc_rv_mem_arb
    import svc_rv_mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wstrb,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,

    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wstrb,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,

    output logic [AW-1:0]     sram_rd_addr,
    input  logic [DW-1:0]     sram_rd_data,
    output logic              sram_wr_en,
    output logic [AW-1:0]     sram_wr_addr,
    output logic [DW-1:0]     sram_wr_data,
    output logic [DW/8-1:0]   sram_wr_strb,

    output logic              starved
);

    logic          g0;
    logic          g1;
    logic          force_grant;
    logic          rd_go;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] rd_addr_q;
    rd_owner_t     rd_owner;

    svc_rv_mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .req         (m1_valid),
        .grant       (g1),
        .force_grant (force_grant)
    );

    // Grants are gated by rst so nothing is accepted (and nothing written)
    // while reset is held, even though the grant path is combinational.
    assign g1 = ~rst & m1_valid & (~m0_valid | force_grant);
    assign g0 = ~rst & m0_valid & ~g1;

    assign m0_ready = g0;
    assign m1_ready = g1;

    assign rd_go    = (g0 & ~m0_we) | (g1 & ~m1_we);
    assign req_addr = g1 ? m1_addr : m0_addr;

    // Write path: payload follows the granted port; enable only on a granted write.
    assign sram_wr_en   = (g0 & m0_we) | (g1 & m1_we);
    assign sram_wr_addr = req_addr;
    assign sram_wr_data = g1 ? m1_wdata : m0_wdata;
    assign sram_wr_strb = g1 ? m1_wstrb : m0_wstrb;

    // Read address is passed through on a granted read and otherwise held,
    // so the SRAM's registered read does not see spurious address changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
        end else if (rd_go) begin
            rd_addr_q <= req_addr;
        end
    end

    assign sram_rd_addr = rd_go ? req_addr : rd_addr_q;

    // Owner of the read data arriving next cycle, plus the starvation pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= '0;
            starved  <= 1'b0;
        end else begin
            rd_owner.valid <= rd_go;
            rd_owner.port  <= g1 ? PORT_DBG : PORT_CPU;
            // A port-1 grant while port 0 also requests can only be forced.
            starved        <= g1 & m0_valid;
        end
    end

    assign m0_rvalid = rd_owner.valid & (rd_owner.port == PORT_CPU);
    assign m1_rvalid = rd_owner.valid & (rd_owner.port == PORT_DBG);
    assign m0_rdata  = sram_rd_data;
    assign m1_rdata  = sram_rd_data;

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
module tb_svc_rv_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0]  m0_addr;
    logic [DW-1:0]  m0_wdata, m0_rdata;
    logic [SW-1:0]  m0_wstrb;
    logic           m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0]  m1_addr;
    logic [DW-1:0]  m1_wdata, m1_rdata;
    logic [SW-1:0]  m1_wstrb;
    logic [AW-1:0]  sram_rd_addr, sram_wr_addr;
    logic [DW-1:0]  sram_rd_data, sram_wr_data;
    logic           sram_wr_en;
    logic [SW-1:0]  sram_wr_strb;
    logic           starved;

    svc_rv_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data), .sram_wr_strb(sram_wr_strb),
        .starved(starved)
    );

    // ---------------- SRAM stand-in (registered read, strobed write) ----------------
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        sram_rd_data <= mem[sram_rd_addr[7:2]];
        if (sram_wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (sram_wr_strb[b]) mem[sram_wr_addr[7:2]][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
            end
        end
    end

    // ---------------- check bookkeeping ----------------
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // Model memory is updated from the requests the spec says must be accepted;
    // the response queue holds {port, data} for reads owed next cycle.
    logic [DW-1:0] model_mem [64];
    logic [DW:0]   exp_q[$];
    int            refused = 0;
    logic          exp_starved = 1'b0;
    logic [AW-1:0] last_rd_addr = '0;
    logic          have_rd = 1'b0;
    logic          eg0, eg1;
    logic [DW:0]   head;
    logic [AW-1:0] ea;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_m0_ready", m0_ready, 1'b0);
            check("rst_m1_ready", m1_ready, 1'b0);
            check("rst_wr_en", sram_wr_en, 1'b0);
            check("rst_m0_rvalid", m0_rvalid, 1'b0);
            check("rst_m1_rvalid", m1_rvalid, 1'b0);
            check("rst_starved", starved, 1'b0);
            exp_q.delete();
            refused = 0;
            exp_starved = 1'b0;
            have_rd = 1'b0;
        end else begin
            // port 1 wins if port 0 is silent or port 1 has been refused STARVE_MAX times
            eg1 = m1_valid && (!m0_valid || refused == STARVE_MAX);
            eg0 = m0_valid && !eg1;
            check("m0_ready", m0_ready, eg0);
            check("m1_ready", m1_ready, eg1);
            check("starved", starved, exp_starved);

            // response owed from last cycle
            if (exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check("m0_rvalid", m0_rvalid, !head[DW]);
                check("m1_rvalid", m1_rvalid, head[DW]);
                check("rdata", head[DW] ? m1_rdata : m0_rdata, head[DW-1:0]);
            end else begin
                check("m0_rvalid_idle", m0_rvalid, 1'b0);
                check("m1_rvalid_idle", m1_rvalid, 1'b0);
            end

            ea = eg1 ? m1_addr : m0_addr;
            if ((eg0 && m0_we) || (eg1 && m1_we)) begin
                check("wr_en", sram_wr_en, 1'b1);
                check("wr_addr", sram_wr_addr, ea);
                check("wr_data", sram_wr_data, eg1 ? m1_wdata : m0_wdata);
                check("wr_strb", sram_wr_strb, eg1 ? m1_wstrb : m0_wstrb);
                for (int b = 0; b < SW; b++) begin
                    if ((eg1 ? m1_wstrb[b] : m0_wstrb[b]))
                        model_mem[ea[7:2]][b*8 +: 8] = eg1 ? m1_wdata[b*8 +: 8] : m0_wdata[b*8 +: 8];
                end
            end else begin
                check("wr_en_off", sram_wr_en, 1'b0);
                if (eg0 || eg1) begin
                    check("rd_addr", sram_rd_addr, ea);
                    exp_q.push_back({eg1, model_mem[ea[7:2]]});
                    last_rd_addr = ea;
                    have_rd = 1'b1;
                end else if (have_rd) begin
                    check("rd_addr_hold", sram_rd_addr, last_rd_addr);
                end
            end

            exp_starved = eg1 && m0_valid;
            if (m1_valid && !eg1) refused = (refused < STARVE_MAX) ? refused + 1 : STARVE_MAX;
            else refused = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    endtask

    task automatic drive_m0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        m0_valid = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    endtask

    task automatic drive_m1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        m1_valid = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    endtask

    // ---------------- directed stimulus ----------------
    logic [9:0]  gseq;
    logic [10:0] sseq;
    logic [4:0]  gseq5;
    int          wr_seen;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = DW'(i) * 32'h0101_0101;
            model_mem[i] = DW'(i) * 32'h0101_0101;
        end
        mem[0] = 32'hAAAA_0000;  model_mem[0] = 32'hAAAA_0000;
        mem[1] = 32'hBBBB_0004;  model_mem[1] = 32'hBBBB_0004;
        mem[4] = 32'hDEAD_BEEF;  model_mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'hFFFF_FFFF;  model_mem[8] = 32'hFFFF_FFFF;
        idle_all();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();

        // 1. port 0 read only
        drive_m0(0, 32'h10, '0, '0);
        @(negedge clk);
        check("t1_m0_ready", m0_ready, 1'b1);
        tick();
        idle_all();
        @(negedge clk);
        check("t1_m0_rvalid", m0_rvalid, 1'b1);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1_m1_rvalid", m1_rvalid, 1'b0);
        tick();

        // 2. contention for 10 cycles
        gseq = '0; sseq = '0;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) begin
                drive_m0(0, 32'h0, '0, '0);
                drive_m1(0, 32'h4, '0, '0);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (i < 10) gseq[i] = m1_ready;
            sseq[i] = starved;
            tick();
        end
        check("t2_grants", gseq, 10'b10_0001_0000);
        check("t2_starved", sseq, 11'b100_0010_0000);
        idle_all();
        tick();

        // 3. port 1 strobed write then read back
        drive_m1(1, 32'h20, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        check("t3_wr_ready", m1_ready, 1'b1);
        tick();
        drive_m1(0, 32'h20, '0, '0);
        @(negedge clk);
        check("t3_rd_ready", m1_ready, 1'b1);
        tick();
        idle_all();
        @(negedge clk);
        check("t3_rvalid", m1_rvalid, 1'b1);
        check("t3_rdata", m1_rdata, 32'hFFFF_5678);
        tick();

        // 4. interleaved reads on consecutive cycles
        drive_m0(0, 32'h0, '0, '0);
        tick();
        idle_all();
        drive_m1(0, 32'h4, '0, '0);
        @(negedge clk);
        check("t4_m0_rvalid", m0_rvalid, 1'b1);
        check("t4_m0_rdata", m0_rdata, 32'hAAAA_0000);
        check("t4_m1_rvalid_a", m1_rvalid, 1'b0);
        tick();
        idle_all();
        @(negedge clk);
        check("t4_m1_rvalid", m1_rvalid, 1'b1);
        check("t4_m1_rdata", m1_rdata, 32'hBBBB_0004);
        check("t4_m0_rvalid_b", m0_rvalid, 1'b0);
        tick();

        // 5. reset while port 1 read would be accepted, with 3 refusals built up
        for (int i = 0; i < 3; i++) begin
            drive_m0(0, 32'h0, '0, '0);
            drive_m1(0, 32'h4, '0, '0);
            tick();
        end
        m0_valid = 0;
        rst = 1;
        @(negedge clk);
        check("t5_rst_ready", m1_ready, 1'b0);
        tick();
        idle_all();
        tick();
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_no_rvalid0", m0_rvalid, 1'b0);
            check("t5_no_rvalid1", m1_rvalid, 1'b0);
            tick();
        end
        gseq5 = '0;
        for (int i = 0; i < 5; i++) begin
            drive_m0(0, 32'h10, '0, '0);
            drive_m1(0, 32'h4, '0, '0);
            @(negedge clk);
            gseq5[i] = m1_ready;
            tick();
        end
        check("t5_grants", gseq5, 5'b10000);
        idle_all();
        tick();
        tick();

        // 6. idle
        wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_wr_en || m0_rvalid || m1_rvalid) wr_seen++;
            tick();
        end
        check("t6_idle_activity", wr_seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
